// File: rtl/ucode_sequencer.sv
// Microcode sequencer: owns the instruction register and the T-state counter and picks the control word for each cycle.
// Optional single-step mode is enabled by defining UCODE_SEQ_STEP_EN.
module ucode_sequencer #(
  parameter logic [15:0] FETCH0_UINSTR = 16'h0000,
  parameter logic [15:0] FETCH1_UINSTR = 16'h0000,
  parameter int          RT_BIT        = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_ready,
  input  logic        halt,
  input  logic [15:0] bus_in,
  input  logic [15:0] rom_uinstr,
`ifdef UCODE_SEQ_STEP_EN
  input  logic        step,
  output logic        stepping,
`endif
  output logic [15:0] instr,
  output logic [2:0]  T,
  output logic [15:0] uinstr,
  output logic        instr_done
);

  logic [15:0] instr_q, instr_d;
  logic [2:0]  t_q, t_d;
  logic        advance;
  logic        gate_ok;

`ifdef UCODE_SEQ_STEP_EN
  logic step_q;
  logic armed_q, armed_d;

  // T0 only leaves when a step edge has armed us; later T-states run freely.
  assign gate_ok  = (t_q != 3'd0) || armed_q;
  assign stepping = (t_q == 3'd0) && !armed_q;

  always_comb begin
    armed_d = armed_q;
    if (step && !step_q) armed_d = 1'b1;
    else if (instr_done) armed_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      step_q  <= step;
      armed_q <= armed_d;
    end
  end
`else
  assign gate_ok = 1'b1;
`endif

  always_comb begin
    uinstr = rom_uinstr;
    if (t_q == 3'd0)      uinstr = FETCH0_UINSTR;
    else if (t_q == 3'd1) uinstr = FETCH1_UINSTR;

    advance = mem_ready && !(t_q == 3'd0 && halt) && gate_ok;

    t_d     = t_q;
    instr_d = instr_q;
    if (advance) begin
      case (t_q)
        3'd0: t_d = 3'd1;
        3'd1: begin
          t_d     = 3'd2;
          instr_d = bus_in;
        end
        // RT is only honoured once fetch is complete.
        default: t_d = (rom_uinstr[RT_BIT] || t_q == 3'd7) ? 3'd0 : t_q + 3'd1;
      endcase
    end

    instr_done = advance && (t_d == 3'd0) && (t_q != 3'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      t_q     <= 3'd0;
      instr_q <= 16'h0000;
    end else begin
      t_q     <= t_d;
      instr_q <= instr_d;
    end
  end

  assign T     = t_q;
  assign instr = instr_q;

endmodule

// File: tb/tb_ucode_sequencer.sv
// Directed bench for ucode_sequencer: vector table plus hand sequences for halt, reset abort and step mode.
module tb_ucode_sequencer;
  localparam logic [15:0] F0 = 16'hA001;
  localparam logic [15:0] F1 = 16'hB002;

  logic        clk = 1'b0;
  logic        reset, mem_ready, halt;
  logic [15:0] bus_in, rom_uinstr;
  logic [15:0] instr, uinstr;
  logic [2:0]  T;
  logic        instr_done;
`ifdef UCODE_SEQ_STEP_EN
  logic step, stepping;
`endif

  int npass = 0;
  int ntot  = 0;

  ucode_sequencer #(.FETCH0_UINSTR(F0), .FETCH1_UINSTR(F1), .RT_BIT(15)) dut (
    .clk(clk), .reset(reset), .mem_ready(mem_ready), .halt(halt),
    .bus_in(bus_in), .rom_uinstr(rom_uinstr),
`ifdef UCODE_SEQ_STEP_EN
    .step(step), .stepping(stepping),
`endif
    .instr(instr), .T(T), .uinstr(uinstr), .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy, hlt;
    logic [15:0] bus, rom;
    logic [2:0]  t;
    logic [15:0] ins, u;
    logic        done;
  } vec_t;

  function automatic vec_t mk(logic rdy, logic hlt, logic [15:0] bus, logic [15:0] rom,
                              logic [2:0] t, logic [15:0] ins, logic [15:0] u, logic done);
    vec_t v;
    v.rdy = rdy; v.hlt = hlt; v.bus = bus; v.rom = rom;
    v.t = t; v.ins = ins; v.u = u; v.done = done;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vt[26];

  initial begin
    reset = 1'b1; mem_ready = 1'b1; halt = 1'b0; bus_in = 16'h0; rom_uinstr = 16'h0;
`ifdef UCODE_SEQ_STEP_EN
    step = 1'b0;
`endif
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_T", {13'd0, T}, 16'd0);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_uinstr", uinstr, F0);
    chk("rst_done", {15'd0, instr_done}, 16'd0);

`ifndef UCODE_SEQ_STEP_EN
    // 8-cycle instruction, then RT at T2, stall in T1, RT under stall, halt at T0.
    vt[0]  = mk(1,0,16'h1234,16'h0000, 0,16'h0000,F0,0);
    vt[1]  = mk(1,0,16'h1234,16'h0000, 1,16'h0000,F1,0);
    vt[2]  = mk(1,0,16'h1234,16'h0102, 2,16'h1234,16'h0102,0);
    vt[3]  = mk(1,0,16'h1234,16'h0103, 3,16'h1234,16'h0103,0);
    vt[4]  = mk(1,0,16'h1234,16'h0104, 4,16'h1234,16'h0104,0);
    vt[5]  = mk(1,0,16'h1234,16'h0105, 5,16'h1234,16'h0105,0);
    vt[6]  = mk(1,0,16'h1234,16'h0106, 6,16'h1234,16'h0106,0);
    vt[7]  = mk(1,0,16'h1234,16'h0107, 7,16'h1234,16'h0107,1);
    vt[8]  = mk(1,0,16'h00C3,16'h0000, 0,16'h1234,F0,0);
    vt[9]  = mk(1,0,16'h00C3,16'h8000, 1,16'h1234,F1,0);
    vt[10] = mk(1,0,16'h00C3,16'h8000, 2,16'h00C3,16'h8000,1);
    vt[11] = mk(1,0,16'hAAAA,16'h0000, 0,16'h00C3,F0,0);
    vt[12] = mk(0,0,16'hAAAA,16'h0000, 1,16'h00C3,F1,0);
    vt[13] = mk(0,0,16'hAAAA,16'h0000, 1,16'h00C3,F1,0);
    vt[14] = mk(0,0,16'hAAAA,16'h0000, 1,16'h00C3,F1,0);
    vt[15] = mk(0,0,16'hAAAA,16'h0000, 1,16'h00C3,F1,0);
    vt[16] = mk(1,0,16'h5555,16'h0000, 1,16'h00C3,F1,0);
    vt[17] = mk(1,0,16'h5555,16'h0202, 2,16'h5555,16'h0202,0);
    vt[18] = mk(0,0,16'h5555,16'h8203, 3,16'h5555,16'h8203,0);
    vt[19] = mk(1,0,16'h5555,16'h8203, 3,16'h5555,16'h8203,1);
    vt[20] = mk(1,1,16'h5555,16'h0000, 0,16'h5555,F0,0);
    vt[21] = mk(1,1,16'h5555,16'h0000, 0,16'h5555,F0,0);
    vt[22] = mk(0,0,16'h5555,16'h0000, 0,16'h5555,F0,0);
    vt[23] = mk(1,0,16'h0777,16'h0000, 0,16'h5555,F0,0);
    vt[24] = mk(1,0,16'h0777,16'h0000, 1,16'h5555,F1,0);
    vt[25] = mk(1,1,16'h0777,16'h8000, 2,16'h0777,16'h8000,1);

    for (int i = 0; i < 26; i++) begin
      mem_ready = vt[i].rdy; halt = vt[i].hlt; bus_in = vt[i].bus; rom_uinstr = vt[i].rom;
      #1;
      chk($sformatf("v%0d_T", i), {13'd0, T}, {13'd0, vt[i].t});
      chk($sformatf("v%0d_instr", i), instr, vt[i].ins);
      chk($sformatf("v%0d_uinstr", i), uinstr, vt[i].u);
      chk($sformatf("v%0d_done", i), {15'd0, instr_done}, {15'd0, vt[i].done});
      tick();
    end

    // halt raised mid-instruction only parks the sequencer after it finishes.
    mem_ready = 1'b1; halt = 1'b0; bus_in = 16'h0ABC; rom_uinstr = 16'h0000;
    #1;
    chk("h_T0", {13'd0, T}, 16'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("h_T4", {13'd0, T}, 16'd4);
    chk("h_instr", instr, 16'h0ABC);
    halt = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("h_T7", {13'd0, T}, 16'd7);
    chk("h_done7", {15'd0, instr_done}, 16'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("h_park%0d_T", i), {13'd0, T}, 16'd0);
      chk($sformatf("h_park%0d_done", i), {15'd0, instr_done}, 16'd0);
      chk($sformatf("h_park%0d_instr", i), instr, 16'h0ABC);
      tick();
    end
    halt = 1'b0;
    tick();
    chk("h_resume_T", {13'd0, T}, 16'd1);

    // reset mid-instruction aborts without an instr_done.
    bus_in = 16'hBEEF;
    tick();
    chk("r_T2", {13'd0, T}, 16'd2);
    chk("r_instr", instr, 16'hBEEF);
    for (int i = 0; i < 3; i++) tick();
    chk("r_T5", {13'd0, T}, 16'd5);
    reset = 1'b1;
    #1;
    chk("r_done_pre", {15'd0, instr_done}, 16'd0);
    tick();
    chk("r_T", {13'd0, T}, 16'd0);
    chk("r_instr_clr", instr, 16'h0000);
    chk("r_done_post", {15'd0, instr_done}, 16'd0);
    reset = 1'b0;
    #1;
    chk("r_uinstr", uinstr, F0);
`else
    // Single-step: two pulses 10 cycles apart, RT at T3, parked at T0 between them.
    chk("s_stepping0", {15'd0, stepping}, 16'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("s_idle%0d_T", i), {13'd0, T}, 16'd0);
    end
    for (int p = 0; p < 2; p++) begin
      step = 1'b1;
      rom_uinstr = 16'h0000;
      tick();
      step = 1'b0;
      #1;
      chk($sformatf("s%0d_armed", p), {15'd0, stepping}, 16'd0);
      chk($sformatf("s%0d_T0", p), {13'd0, T}, 16'd0);
      tick();
      chk($sformatf("s%0d_T1", p), {13'd0, T}, 16'd1);
      tick();
      chk($sformatf("s%0d_T2", p), {13'd0, T}, 16'd2);
      chk($sformatf("s%0d_done2", p), {15'd0, instr_done}, 16'd0);
      tick();
      rom_uinstr = 16'h8000;
      #1;
      chk($sformatf("s%0d_T3", p), {13'd0, T}, 16'd3);
      chk($sformatf("s%0d_done3", p), {15'd0, instr_done}, 16'd1);
      tick();
      rom_uinstr = 16'h0000;
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("s%0d_park%0d_T", p, i), {13'd0, T}, 16'd0);
        chk($sformatf("s%0d_park%0d_stp", p, i), {15'd0, stepping}, 16'd1);
        tick();
      end
    end
`endif

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
